// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with one outstanding line fill.
// A hit answers one cycle after the request. A miss fetches the whole line
// from backing memory, writes it into the cache, then answers from that line.
module icache_dm #(
    parameter int NLINES = 4,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  flush,
    output logic                  ready,
    output logic                  rsp_valid,
    output logic [31:0]           rd,
    output logic                  hit,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [32*WORDS-1:0]   mem_rdata,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);

    localparam int WOFF_W = $clog2(WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(NLINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;

    // Line storage: valid bits are resettable, tags and data are not.
    logic [NLINES-1:0]     valid_q;
    logic [TAG_W-1:0]      tag_q  [NLINES];
    logic [32*WORDS-1:0]   data_q [NLINES];

    // Fields of the outstanding miss, captured when the miss is accepted.
    logic [TAG_W-1:0]      miss_tag_q;
    logic [IDX_W-1:0]      miss_idx_q;
    logic [WOFF_W-1:0]     miss_word_q;
    logic                  flush_pend_q;

    logic                  rsp_valid_q, hit_q, mem_req_q;
    logic [31:0]           rd_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [15:0]           hit_cnt_q, miss_cnt_q;

    // Decoded control for this cycle.
    logic                  ready_s, hit_acc_s, miss_acc_s, fill_s, resp_s, flush_now_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [WOFF_W-1:0]     req_word_s;
    logic                  lookup_hit_s;
    logic                  addr_unused_s;

    // Byte-within-word bits carry no information for a word fetch.
    assign addr_unused_s = &{1'b0, addr[1:0]};

    assign req_idx_s    = addr[OFF_W +: IDX_W];
    assign req_tag_s    = addr[ADDR_W-1 -: TAG_W];
    assign req_word_s   = addr[2 +: WOFF_W];
    assign lookup_hit_s = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);

    function automatic logic [31:0] word_sel(input logic [32*WORDS-1:0] line,
                                             input logic [WOFF_W-1:0]   w);
        word_sel = line[{w, 5'b00000} +: 32];
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_d     = state_q;
        ready_s     = 1'b0;
        hit_acc_s   = 1'b0;
        miss_acc_s  = 1'b0;
        fill_s      = 1'b0;
        resp_s      = 1'b0;
        flush_now_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_s = ~flush;
                if (flush) begin
                    flush_now_s = 1'b1;
                end else if (req) begin
                    if (lookup_hit_s) begin
                        hit_acc_s = 1'b1;
                    end else begin
                        miss_acc_s = 1'b1;
                        state_d    = S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    fill_s  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_RESP: begin
                resp_s      = 1'b1;
                state_d     = S_IDLE;
                // A flush seen during the fill takes effect as we return to IDLE.
                flush_now_s = flush_pend_q | flush;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line data and tag write on fill completion
    always_ff @(posedge clk) begin
        if (fill_s && !reset) begin
            data_q[miss_idx_q] <= mem_rdata;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

    // Valid bits, miss bookkeeping, registered outputs and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            miss_word_q  <= '0;
            rsp_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            rd_q         <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= 16'd0;
            miss_cnt_q   <= 16'd0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (flush_now_s) begin
                valid_q <= '0;
            end else if (fill_s) begin
                valid_q[miss_idx_q] <= 1'b1;
            end

            if (flush_now_s) begin
                flush_pend_q <= 1'b0;
            end else if ((state_q == S_FILL) && flush) begin
                flush_pend_q <= 1'b1;
            end

            if (hit_acc_s) begin
                rsp_valid_q <= 1'b1;
                hit_q       <= 1'b1;
                rd_q        <= word_sel(data_q[req_idx_s], req_word_s);
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
            end

            if (miss_acc_s) begin
                miss_tag_q  <= req_tag_s;
                miss_idx_q  <= req_idx_s;
                miss_word_q <= req_word_s;
                mem_req_q   <= 1'b1;
                mem_addr_q  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end

            if (fill_s) begin
                mem_req_q <= 1'b0;
            end

            if (resp_s) begin
                rsp_valid_q <= 1'b1;
                hit_q       <= 1'b0;
                rd_q        <= word_sel(data_q[miss_idx_q], miss_word_q);
            end
        end
    end

    assign ready     = ready_s;
    assign rsp_valid = rsp_valid_q;
    assign hit       = hit_q;
    assign rd        = rd_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm (NLINES=4, WORDS=4, ADDR_W=32).
// Reference: backing memory is a fixed function of address, so every fetch
// must return that word; a per-index record of which line is resident
// predicts hit or miss.
module tb_icache_dm;

    logic         clk = 1'b0;
    logic         reset, req, flush, mem_ack;
    logic [31:0]  addr;
    logic [127:0] mem_rdata;
    logic         ready, rsp_valid, hit, mem_req;
    logic [31:0]  rd, mem_addr;
    logic [15:0]  hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;

    bit          m_valid [4];
    logic [31:0] m_line  [4];
    int          m_hits, m_misses;

    icache_dm #(.NLINES(4), .WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .flush(flush),
        .ready(ready), .rsp_valid(rsp_valid), .rd(rd), .hit(hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] base);
        line_data = {mem_word(base + 32'd12), mem_word(base + 32'd8),
                     mem_word(base + 32'd4),  mem_word(base)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    task automatic bump_hits();
        if (m_hits < 65535) m_hits++;
    endtask

    task automatic bump_misses();
        if (m_misses < 65535) m_misses++;
    endtask

    // One complete fetch; n = cycles from mem_req rise to mem_ack inclusive.
    task automatic do_fetch(input logic [31:0] a, input int n, input bit flush_mid);
        logic [31:0] exp_rd;
        logic [31:0] line_a;
        bit          exp_hit;
        int          idx, guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait got=%b exp=1", ready);
        end
        idx     = int'((a >> 4) & 32'd3);
        line_a  = a >> 4;
        exp_hit = m_valid[idx] && (m_line[idx] == line_a);
        exp_rd  = mem_word(a & ~32'h3);
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        req  = 1'b0;
        addr = $urandom;
        if (exp_hit) begin
            bump_hits();
            checks++;
            if (rsp_valid !== 1'b1 || hit !== 1'b1 || rd !== exp_rd) begin
                failures++;
                $display("FAIL hit_rsp a=%h got v=%b h=%b rd=%h exp v=1 h=1 rd=%h",
                         a, rsp_valid, hit, rd, exp_rd);
            end
        end else begin
            bump_misses();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== (a & ~32'hF) || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL miss_req a=%h got mreq=%b maddr=%h v=%b exp mreq=1 maddr=%h v=0",
                         a, mem_req, mem_addr, rsp_valid, a & ~32'hF);
            end
            flush = flush_mid;
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
                flush = 1'b0;
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== (a & ~32'hF) || rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_wait a=%h k=%0d got mreq=%b maddr=%h v=%b exp 1 %h 0",
                             a, k, mem_req, mem_addr, rsp_valid, a & ~32'hF);
                end
            end
            mem_ack   = 1'b1;
            mem_rdata = line_data(a & ~32'hF);
            @(negedge clk);
            flush     = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL fill_done a=%h got mreq=%b v=%b exp 0 0", a, mem_req, rsp_valid);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || hit !== 1'b0 || rd !== exp_rd) begin
                failures++;
                $display("FAIL miss_rsp a=%h got v=%b h=%b rd=%h exp v=1 h=0 rd=%h",
                         a, rsp_valid, hit, rd, exp_rd);
            end
            m_valid[idx] = 1'b1;
            m_line[idx]  = line_a;
            if (flush_mid) model_clear();
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (hit_cnt !== m_hits[15:0] || miss_cnt !== m_misses[15:0]) begin
            failures++;
            $display("FAIL %s got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     name, hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_hits = 0;
        m_misses = 0;
        checks++;
        if (ready !== 1'b1 || rsp_valid !== 1'b0 || hit !== 1'b0 || rd !== 32'd0 ||
            mem_req !== 1'b0 || mem_addr !== 32'd0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b h=%b rd=%h mreq=%b maddr=%h hc=%0d mc=%0d exp 1 0 0 0 0 0 0 0",
                     ready, rsp_valid, hit, rd, mem_req, mem_addr, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_cold_miss_and_rehit();
        logic [31:0] hold;
        do_fetch(32'h10, 3, 1'b0);
        check_counters("cold_miss_cnt");
        do_fetch(32'h1C, 2, 1'b0);
        check_counters("rehit_cnt");
        hold = mem_word(32'h1C);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rd !== hold) begin
            failures++;
            $display("FAIL rd_hold got v=%b rd=%h exp v=0 rd=%h", rsp_valid, rd, hold);
        end
    endtask

    task automatic test_conflict();
        do_fetch(32'h50, 1, 1'b0);
        do_fetch(32'h10, 2, 1'b0);
        do_fetch(32'h14, 1, 1'b0);
        check_counters("conflict_cnt");
    endtask

    task automatic test_flush();
        do_fetch(32'h20, 2, 1'b1);
        do_fetch(32'h20, 1, 1'b0);
        do_fetch(32'h30, 1, 1'b0);
        flush = 1'b1;
        req   = 1'b1;
        addr  = 32'h30;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", ready);
        end
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
        model_clear();
        checks++;
        if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_noaccept got v=%b mreq=%b exp 0 0", rsp_valid, mem_req);
        end
        do_fetch(32'h30, 1, 1'b0);
        check_counters("flush_cnt");
    endtask

    task automatic test_reset_fill();
        bit saw_rsp;
        req  = 1'b1;
        addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_hits = 0;
        m_misses = 0;
        checks++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got mreq=%b v=%b exp 0 0", mem_req, rsp_valid);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp) begin
            failures++;
            $display("FAIL late_ack_rsp got rsp_valid=1 exp 0");
        end
        do_fetch(32'h10, 2, 1'b0);
        check_counters("reset_fill_cnt");
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          saw;
        for (int it = 0; it < 200; it++) begin
            a = $urandom_range(0, 255);
            do_fetch(a, $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                mem_ack = 1'b0;
                saw = (rsp_valid !== 1'b0) || (mem_req !== 1'b0);
                checks++;
                if (saw) begin
                    failures++;
                    $display("FAIL idle_ack got v=%b mreq=%b exp 0 0", rsp_valid, mem_req);
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
        end
        check_counters("random_cnt");
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [8];
        logic [31:0] exp_rd;
        for (int i = 0; i < 4; i++) do_fetch(32'h10 * i, 1, 1'b0);
        for (int i = 0; i < 8; i++) seq[i] = $urandom_range(0, 63);
        req  = 1'b1;
        addr = seq[0];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bump_hits();
            exp_rd = mem_word(seq[i] & ~32'h3);
            if (i < 7) addr = seq[i + 1];
            else       req  = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || hit !== 1'b1 || rd !== exp_rd) begin
                failures++;
                $display("FAIL b2b i=%0d a=%h got v=%b h=%b rd=%h exp v=1 h=1 rd=%h",
                         i, seq[i], rsp_valid, hit, rd, exp_rd);
            end
        end
        check_counters("b2b_cnt");
    endtask

    task automatic test_hit_saturation();
        do_fetch(32'h1C, 1, 1'b0);
        req  = 1'b1;
        addr = 32'h1C;
        repeat (65540) begin
            @(negedge clk);
            bump_hits();
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'hFFFF || m_hits != 65535) begin
            failures++;
            $display("FAIL hit_sat got=%h exp=ffff", hit_cnt);
        end
        check_counters("sat_cnt");
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        addr      = 32'd0;
        mem_rdata = 128'd0;
        @(negedge clk);
        test_reset();
        test_cold_miss_and_rehit();
        test_conflict();
        test_flush();
        test_reset_fill();
        test_random();
        test_back_to_back();
        test_hit_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter NLINES, default 4, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  1  CPU fetch request; sampled only when ready=1.
REQ-008 addr  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-009 flush  input  1  invalidate-all request.
REQ-010 ready  output  1  cache can accept req this cycle.
REQ-011 rsp_valid  output  1  one-cycle pulse; rd valid.
REQ-012 rd  output  32  fetched instruction word.
REQ-013 hit  output  1  qualifies rsp_valid: 1 = served from cache, 0 = served after fill.
REQ-014 mem_req  output  1  line-fill request to backing memory.
REQ-015 mem_addr  output  ADDR_W  line-aligned fill address (offset bits zero).
REQ-016 mem_ack  input  1  fill data valid; single-cycle pulse.
REQ-017 mem_rdata  input  32*WORDS  full line; word i at bits [32i+31:32i].
REQ-018 hit_cnt, miss_cnt  output  16 each  saturating event counters.

Function
REQ-019 Address split SHALL be: offset = log2(WORDS)+2 bits, index = next log2(NLINES) bits, tag = remaining ADDR_W-index-offset bits.
REQ-020 Each line SHALL hold valid (1b), tag, data (32*WORDS).
REQ-021 FSM SHALL have states IDLE, FILL, RESP.
REQ-022 ready SHALL be 1 only in IDLE with flush=0.
REQ-023 IDLE, req accepted, line valid and tag match: next cycle rsp_valid=1, hit=1, rd=addressed word; state stays IDLE (back-to-back hits at 1 req/cycle).
REQ-024 IDLE, req accepted, miss: latch addr; next state FILL; mem_req=1 and mem_addr held stable from the next cycle until mem_ack.
REQ-025 FILL, mem_ack=1: write data, tag, valid=1 into the indexed line; mem_req deasserts next cycle; next state RESP.
REQ-026 RESP: rsp_valid=1, hit=0, rd=requested word of the filled line; next state IDLE.
REQ-027 Miss latency SHALL be N+2 cycles from accepted req to rsp_valid, where N is cycles from mem_req rise to mem_ack inclusive.
REQ-028 mem_ack outside FILL SHALL be ignored.
REQ-029 rd SHALL hold its last value when rsp_valid=0.
REQ-030 flush in IDLE SHALL clear all valid bits at that edge; a simultaneous req is not accepted (ready=0).
REQ-031 flush in FILL or RESP SHALL be recorded; the fill completes and its response is delivered, then all valid bits clear on entry to IDLE (including the new line).
REQ-032 hit_cnt SHALL increment per hit response, miss_cnt per accepted miss; both saturate at 16'hFFFF.
REQ-033 Conflicting tags on one index SHALL evict: the fill overwrites the line unconditionally.

Reset
REQ-034 reset SHALL force state IDLE, all valid bits 0, pending flush 0, ready=1, rsp_valid=0, hit=0, rd=0, mem_req=0, mem_addr=0, counters 0; data/tag arrays need not reset.
REQ-035 reset mid-FILL SHALL abort the fill: mem_req=0 next cycle, no line written, a later mem_ack ignored.

Verification
REQ-036 Cold miss: req addr=0x10, mem_ack after 3 cycles, mem_rdata words {D0..D3} -> mem_addr=0x10, rsp_valid with hit=0, rd=D0 at cycle 5; miss_cnt=1.
REQ-037 Re-read addr=0x1C after REQ-036 fill -> rsp_valid next cycle, hit=1, rd=D3; hit_cnt=1.
REQ-038 Conflict: fill 0x10, then req 0x50 (same index 1, tag 1) -> miss, mem_addr=0x40? no: mem_addr=0x50; subsequent 0x10 misses again.
REQ-039 Flush during FILL of 0x20 -> response delivered with hit=0, then req 0x20 misses.
REQ-040 Reset asserted 1 cycle after mem_req rises, mem_ack arrives later -> no rsp_valid, req 0x10 misses.
REQ-041 Force hit_cnt to 16'hFFFF via 65536 hits -> value stays 16'hFFFF.
